// File: rtl/redmule_pkg.sv
// redmule_pkg: shared constants and types for the RedMulE MX datapath.
//   MX_BLOCK_SIZE         elements that share one exponent
//   MX_EXP_W              width of one shared exponent
//   mx_exp_unpack_state_e state encoding of the exponent unpacker
package redmule_pkg;

  localparam int unsigned MX_BLOCK_SIZE = 32;
  localparam int unsigned MX_EXP_W      = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BEAT = 2'd1,
    EMIT      = 2'd2
  } mx_exp_unpack_state_e;

endpackage

// File: rtl/redmule_mx_exp_unpacker.sv
// redmule_mx_exp_unpacker: turns wide exponent beats read linearly from memory
// into a stream of one shared exponent per MX block, counted against a
// per-job block total. Bytes past the last block of the final beat are dropped.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   clear_i                 synchronous soft clear (back to IDLE, no done)
//   start_i, total_blocks_i job start and number of blocks of the job
//   beat_valid_i/_ready_o   exponent beat handshake, beat_data_i byte 0 first
//   exp_valid_o/_ready_i    exponent handshake, exp_o value, exp_last_o last
//   busy_o                  job in progress
//   done_o                  one-cycle completion pulse
//   overrun_o               sticky surplus-beat flag (optional, see below)
//
// Configuration macro: REDMULE_MX_EXP_OVERRUN_EN. When defined, beats arriving
// in IDLE after a completed job are swallowed and flagged on overrun_o; when
// undefined the port is absent and such beats stall at the source.
module redmule_mx_exp_unpacker
  import redmule_pkg::*;
#(
  parameter int unsigned EXP_DW = 512,
  parameter int unsigned EXP_W  = MX_EXP_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [31:0]       total_blocks_i,
  input  logic              beat_valid_i,
  input  logic [EXP_DW-1:0] beat_data_i,
  output logic              beat_ready_o,
  output logic              exp_valid_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              exp_last_o,
  input  logic              exp_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef REDMULE_MX_EXP_OVERRUN_EN
  ,
  output logic              overrun_o
`endif
);

  localparam int unsigned BYTES = EXP_DW / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  mx_exp_unpack_state_e state_q, state_d;
  logic [31:0]       rem_q, rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [EXP_DW-1:0] beat_q, beat_d;
  logic              exp_valid_q, exp_valid_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              exp_last_q, exp_last_d;
  logic              done_q, done_d;

  logic beat_ready;
  logic beat_hs;
  logic exp_hs;
  logic job_end;

`ifdef REDMULE_MX_EXP_OVERRUN_EN
  logic completed_q;
  logic overrun_q;
`endif

  assign beat_hs = beat_valid_i && beat_ready;
  assign exp_hs  = exp_valid_q && exp_ready_i;
  // The handshake that consumes the final exponent of the job.
  assign job_end = (state_q == EMIT) && exp_hs && (rem_q == 32'd1);

  // Beat acceptance: a refill is taken in the same cycle the last byte of the
  // current beat leaves, so beat boundaries cost no bubble.
  always_comb begin
    beat_ready = 1'b0;
    case (state_q)
      WAIT_BEAT: beat_ready = 1'b1;
      EMIT:      beat_ready = exp_ready_i && (idx_q == IDX_LAST) && (rem_q > 32'd1);
`ifdef REDMULE_MX_EXP_OVERRUN_EN
      IDLE:      beat_ready = completed_q;
`else
      IDLE:      beat_ready = 1'b0;
`endif
      default:   beat_ready = 1'b0;
    endcase
  end

  // Next-state, block counter, byte index and beat buffer; the exponent
  // outputs are derived from the next state so they are plain registers.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      rem_d   = 32'd0;
      idx_d   = {IDX_W{1'b0}};
      beat_d  = {EXP_DW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_d = total_blocks_i;
            if (total_blocks_i != 32'd0) begin
              state_d = WAIT_BEAT;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_BEAT: begin
          if (beat_hs) begin
            beat_d  = beat_data_i;
            idx_d   = {IDX_W{1'b0}};
            state_d = EMIT;
          end else begin
            state_d = WAIT_BEAT;
          end
        end
        EMIT: begin
          if (exp_hs) begin
            // rem_q is at least 1 in EMIT, so this cannot wrap.
            rem_d = rem_q - 32'd1;
            if (rem_q == 32'd1) begin
              state_d = IDLE;
              idx_d   = {IDX_W{1'b0}};
              done_d  = 1'b1;
            end else if (idx_q == IDX_LAST) begin
              idx_d = {IDX_W{1'b0}};
              if (beat_hs) begin
                beat_d = beat_data_i;
              end else begin
                state_d = WAIT_BEAT;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = EMIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    exp_valid_d = (state_d == EMIT);
    exp_last_d  = (state_d == EMIT) && (rem_d == 32'd1);
    if (state_d == EMIT) begin
      exp_d = beat_d[{idx_d, 3'b000} +: EXP_W];
    end else begin
      exp_d = {EXP_W{1'b0}};
    end
  end

  // State, counters, beat buffer and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= 32'd0;
      idx_q       <= {IDX_W{1'b0}};
      beat_q      <= {EXP_DW{1'b0}};
      exp_valid_q <= 1'b0;
      exp_q       <= {EXP_W{1'b0}};
      exp_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      exp_valid_q <= exp_valid_d;
      exp_q       <= exp_d;
      exp_last_q  <= exp_last_d;
      done_q      <= done_d;
    end
  end

`ifdef REDMULE_MX_EXP_OVERRUN_EN
  // Surplus-beat tracking: only a job that ran to completion arms the sink,
  // and any beat swallowed in IDLE latches the sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      completed_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (clear_i) begin
      completed_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (job_end) begin
        completed_q <= 1'b1;
      end else if ((state_q == IDLE) && start_i) begin
        completed_q <= 1'b0;
      end else begin
        completed_q <= completed_q;
      end
      if ((state_q == IDLE) && beat_hs) begin
        overrun_q <= 1'b1;
      end else begin
        overrun_q <= overrun_q;
      end
    end
  end

  assign overrun_o = overrun_q;
`endif

  assign beat_ready_o = beat_ready;
  assign exp_valid_o  = exp_valid_q;
  assign exp_o        = exp_q;
  assign exp_last_o   = exp_last_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule
